key_conditioner: RTL and testbench
==================================

# key_conditioner

Conditions one active-low push-button (KEY[n]) into clean, single-cycle events on the `clk` domain. It sits directly upstream of `counter_16` and drives its count-enable input in place of the raw `!KEY[0]` term. It synchronises and debounces the key, emits one `press_pulse` per press, and optionally generates typematic auto-repeat pulses while the key is held.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz); legal range ≥1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat, 0 gives one pulse per press only.
- `REPEAT_DELAY`, default 25000000: cycles from `press_pulse` to the first repeat pulse; legal range ≥1.
- `REPEAT_RATE`, default 5000000: cycles between subsequent repeat pulses; legal range ≥1.
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `key_n`  in  1  raw asynchronous button, 0 = pressed.
- `pressed`  out  1  debounced level, 1 while the press is accepted.
- `press_pulse`  out  1  one-cycle strobe on an accepted press and on each repeat.
- `release_pulse`  out  1  one-cycle strobe on an accepted release.

## Operation
- Two-flop synchroniser on `key_n` produces `key_s`. Both flops reset to 1 (released).
- One down-counter is shared by all timed states. Width is `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1)`. It reloads on every state transition and never wraps.
- FSM states:
  - IDLE: if `key_s`=0, go to DEB_PRESS and load DEBOUNCE_CYCLES-1.
  - DEB_PRESS:
    - `key_s`=1 (bounce): return to IDLE, no output.
    - Counter reaches 0 with `key_s`=0: go to HELD_DELAY; `press_pulse`=1 for that one cycle; `pressed` goes to 1; load REPEAT_DELAY-1.
  - HELD_DELAY and HELD_REPEAT:
    - `key_s`=1: go to DEB_REL and load DEBOUNCE_CYCLES-1.
    - Else, if counter is 0 and REPEAT_EN=1: `press_pulse` for one cycle, go to (or stay in) HELD_REPEAT, load REPEAT_RATE-1.
    - With REPEAT_EN=0 the counter holds at 0 and no pulse is emitted.
  - DEB_REL:
    - `key_s`=0 (bounce): return to HELD_DELAY and load REPEAT_DELAY-1. The repeat timer restarts and no pulse is emitted.
    - Counter reaches 0 with `key_s`=1: go to IDLE; `release_pulse` for one cycle; `pressed` goes to 0.
- `pressed` is 1 in HELD_DELAY, HELD_REPEAT and DEB_REL.
- `press_pulse` and `release_pulse` are never high in the same cycle.
- All outputs are registered.

## Timing
- Reset values: `pressed`=0, `press_pulse`=0, `release_pulse`=0, state IDLE, counter 0, synchroniser flops 1.
- Let edge E be the first rising edge at which a held-low `key_n` is sampled. `press_pulse` is high in the cycle following edge E+2+DEBOUNCE_CYCLES. The release path has the same latency.
- First repeat pulse comes REPEAT_DELAY cycles after `press_pulse`. Later repeats are spaced REPEAT_RATE cycles apart, measured pulse-to-pulse.
- A bounce of any length shorter than DEBOUNCE_CYCLES produces no output and fully restarts the debounce.
- `rst` mid-operation returns to reset values on the next edge; no `release_pulse` is generated. A key held through reset is re-debounced and yields exactly one fresh `press_pulse`.
- With DEBOUNCE_CYCLES=1, a press needs exactly one sampled-low cycle after synchronisation.

## Structure
- Shared package `key_pkg` holds:
  - the state encoding localparams (IDLE, DEB_PRESS, HELD_DELAY, HELD_REPEAT, DEB_REL; 3-bit);
  - the default timing constants at 50 MHz.
- Sub-module `sync_2ff` (`clk`, `rst`, `d`, `q`; reset value parameter RST_VAL) is reused for any other asynchronous input in the design.
- The FSM, counter and output registers live in `key_conditioner`.

## Test plan
Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3 unless stated.
- Clean press: drive `key_n` 1→0 at edge 0 and hold for 8 cycles, REPEAT_EN=0 -> single `press_pulse` in cycle 6, `pressed`=1 from cycle 6, no further pulses.
- Bounce rejection: drive `key_n` low for 3 cycles, high for 1, low for 3, then high -> no `press_pulse`, `pressed` stays 0 throughout.
- Auto-repeat: hold `key_n` low for 40 cycles, REPEAT_EN=1 -> `press_pulse` at cycles 6, 16, 19, 22, …, every 3 cycles while held.
- Release: release after the accepted press in scenario 1 -> one `release_pulse` 6 cycles after `key_n` rises, `pressed` falls in the same cycle; a 2-cycle release glitch leaves `pressed`=1 and produces no `release_pulse`.
- Reset mid-hold: assert `rst` one cycle while `pressed`=1 and `key_n` stays low -> all outputs 0 next cycle, no `release_pulse`; one new `press_pulse` 6 cycles after `rst` deasserts.
- Defaults smoke test: with default parameters a held key gives `press_pulse` 50002 cycles after `key_n` falls and a first repeat 25000000 cycles after that.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button conditioner.
//   - 3-bit state encodings for the conditioner FSM
//   - default timing constants for a 50 MHz clock
//   - max3 helper used to size the shared down-counter
package key_pkg;

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DEB_PRESS   = 3'd1;
    localparam logic [2:0] HELD_DELAY  = 3'd2;
    localparam logic [2:0] HELD_REPEAT = 3'd3;
    localparam logic [2:0] DEB_REL     = 3'd4;

    // 1 ms debounce, 0.5 s to first repeat, 10 repeats per second at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input.
// Ports:
//   clk  in  sampling clock
//   rst  in  synchronous active-high reset; both flops load RST_VAL
//   d    in  asynchronous input
//   q    out synchronised copy of d (two clocks of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and optionally auto-repeats one
// active-low push-button, producing clean single-cycle events.
// Ports:
//   clk            in  system clock
//   rst            in  synchronous active-high reset
//   key_n          in  raw asynchronous button, 0 = pressed
//   pressed        out debounced level, 1 while a press is accepted
//   press_pulse    out one-cycle strobe on accepted press and each repeat
//   release_pulse  out one-cycle strobe on accepted release
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             RPT_ON     = (REPEAT_EN != 0);

    logic             key_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             cnt_zero;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_n),
        .q   (key_s)
    );

    assign cnt_zero = (cnt_q == '0);

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
        end
    end

    // Next state and counter; every transition reloads the shared counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!key_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = DEB_LOAD;
                end
            end
            DEB_PRESS: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = HELD_DELAY;
                    cnt_d   = DELAY_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HELD_DELAY, HELD_REPEAT: begin
                if (key_s) begin
                    state_d = DEB_REL;
                    cnt_d   = DEB_LOAD;
                end else if (cnt_zero) begin
                    // Without repeat the counter parks at zero
                    if (RPT_ON) begin
                        state_d = HELD_REPEAT;
                        cnt_d   = RATE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DEB_REL: begin
                if (!key_s) begin
                    // Release bounce restarts the repeat timer silently
                    state_d = HELD_DELAY;
                    cnt_d   = DELAY_LOAD;
                end else if (cnt_zero) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values, registered above so pulses align with the new state
    always_comb begin
        press_d   = 1'b0;
        rel_d     = 1'b0;
        pressed_d = 1'b0;
        if (!key_s && cnt_zero) begin
            if (state_q == DEB_PRESS) begin
                press_d = 1'b1;
            end else if (RPT_ON && (state_q == HELD_DELAY || state_q == HELD_REPEAT)) begin
                press_d = 1'b1;
            end
        end
        if (key_s && cnt_zero && state_q == DEB_REL) begin
            rel_d = 1'b1;
        end
        if (state_d == HELD_DELAY || state_d == HELD_REPEAT || state_d == DEB_REL) begin
            pressed_d = 1'b1;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner. Expected pulse events (cycle and kind) are
// queued when stimulus is applied and compared as the DUTs emit pulses.
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int DD = 50000;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_d = 1'b1;
    logic k0 = 1'b1, k1 = 1'b1, kd = 1'b1;
    logic p0, pp0, rp0;
    logic p1, pp1, rp1;
    logic pd, ppd, rpd;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut0 (
        .clk(clk), .rst(rst), .key_n(k0), .pressed(p0), .press_pulse(pp0), .release_pulse(rp0));

    key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut1 (
        .clk(clk), .rst(rst), .key_n(k1), .pressed(p1), .press_pulse(pp1), .release_pulse(rp1));

    key_conditioner dutd (
        .clk(clk), .rst(rst_d), .key_n(kd), .pressed(pd), .press_pulse(ppd), .release_pulse(rpd));

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int rel;
    } ev_t;

    ev_t q[3][$];

    task automatic push(input int i, input int c, input int rel);
        ev_t e;
        e.cyc = c;
        e.rel = rel;
        q[i].push_back(e);
    endtask

    task automatic mon(input int i, input logic pp, input logic rp);
        ev_t e;
        chk("pulse_excl", int'(pp & rp), 0);
        if (pp || rp) begin
            if (q[i].size() == 0) begin
                chk($sformatf("spurious_pulse%0d", i), int'({pp, rp}), 0);
            end else begin
                e = q[i].pop_front();
                chk($sformatf("pulse_cycle%0d", i), cyc, e.cyc);
                chk($sformatf("pulse_kind%0d", i), int'(rp), e.rel);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, pp0, rp0);
        mon(1, pp1, rp1);
        mon(2, ppd, rpd);
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    int c, g, r2, cd, p;
    logic bpat[8];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pressed0", p0, 0);
        chk("rst_press0", pp0, 0);
        chk("rst_rel0", rp0, 0);
        chk("rst_pressed1", p1, 0);
        chk("rst_pressedd", pd, 0);
        rst   = 1'b0;
        rst_d = 1'b0;

        // Default-parameter instance: press runs in the background
        kd = 1'b0;
        cd = cyc;
        push(2, cd + 3 + DD, 0);

        // Clean press without repeat, a short release glitch, then release
        @(negedge clk);
        c  = cyc;
        k0 = 1'b0;
        push(0, c + 3 + D, 0);
        wait_cyc(c + 2 + D);
        chk("s1_pressed_before", p0, 0);
        wait_cyc(c + 3 + D);
        chk("s1_pressed_after", p0, 1);
        wait_cyc(c + 20);
        g  = cyc;
        k0 = 1'b1;
        repeat (2) @(negedge clk);
        k0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s1_glitch_pressed", p0, 1);
        end
        wait_cyc(g + 14);
        k0 = 1'b1;
        push(0, g + 14 + 3 + D, 1);
        wait_cyc(g + 14 + 2 + D);
        chk("s1_rel_before", p0, 1);
        wait_cyc(g + 14 + 3 + D);
        chk("s1_rel_after", p0, 0);
        wait_cyc(g + 30);
        chk("s1_drain", q[0].size(), 0);

        // Bounce: low 3, high 1, low 3, then high
        bpat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            k0 = bpat[i];
            @(negedge clk);
            chk("s2_pressed", p0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s2_pressed", p0, 0);
        end
        chk("s2_drain", q[0].size(), 0);

        // Auto-repeat: hold 40 cycles; key_s stays low through edge c+42
        @(negedge clk);
        c  = cyc;
        k1 = 1'b0;
        push(1, c + 3 + D, 0);
        p = c + 3 + D + RD;
        while (p <= c + 42) begin
            push(1, p, 0);
            p += RR;
        end
        wait_cyc(c + 40);
        k1 = 1'b1;
        push(1, c + 40 + 3 + D, 1);
        wait_cyc(c + 40 + 3 + D + 5);
        chk("s3_pressed_end", p1, 0);
        chk("s3_drain", q[1].size(), 0);

        // Reset while held: no release, then one fresh press after re-debounce
        @(negedge clk);
        c  = cyc;
        k1 = 1'b0;
        push(1, c + 3 + D, 0);
        wait_cyc(c + 12);
        chk("s4_pressed_pre", p1, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("s4_rst_pressed", p1, 0);
        chk("s4_rst_press", pp1, 0);
        chk("s4_rst_rel", rp1, 0);
        rst = 1'b0;
        r2  = cyc;
        push(1, r2 + 3 + D, 0);
        push(1, r2 + 3 + D + RD, 0);
        wait_cyc(r2 + 2 + D);
        chk("s4_pressed_before", p1, 0);
        wait_cyc(r2 + 3 + D);
        chk("s4_pressed_after", p1, 1);
        wait_cyc(r2 + 15);
        k1 = 1'b1;
        push(1, r2 + 15 + 3 + D, 1);
        wait_cyc(r2 + 30);
        chk("s4_drain", q[1].size(), 0);

        // Default timing: press pulse DEBOUNCE_CYCLES+2 after the first sample
        wait_cyc(cd + 2 + DD);
        chk("def_pressed_before", pd, 0);
        wait_cyc(cd + 3 + DD);
        chk("def_pressed_after", pd, 1);
        wait_cyc(cd + 3 + DD + 5);
        chk("def_drain", q[2].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
